// File: rtl/hs_ram_arbiter_if.sv
// hs_ram_arbiter_if
//   Bundles the hiscore engine, pause block, CPU and work-RAM signals that meet
//   at hs_ram_arbiter.
//   slave  : the arbiter's view. Requests, CPU bus and RAM read data come in.
//            Grant, pause request, RAM bus, read data and error go out.
//   master : the surrounding system's view (the reverse directions).
interface hs_ram_arbiter_if #(
  parameter int AW = 12
);
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_we;
  logic [7:0]    hs_rdata;
  logic          hs_grant;
  logic          pause_req;
  logic          cpu_paused;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          timeout_err;

  modport slave (
    input  hs_req, hs_addr, hs_wdata, hs_we, cpu_paused,
           cpu_addr, cpu_wdata, cpu_we, ram_rdata,
    output hs_rdata, hs_grant, pause_req, ram_addr, ram_wdata, ram_we,
           timeout_err
  );

  modport master (
    output hs_req, hs_addr, hs_wdata, hs_we, cpu_paused,
           cpu_addr, cpu_wdata, cpu_we, ram_rdata,
    input  hs_rdata, hs_grant, pause_req, ram_addr, ram_wdata, ram_we,
           timeout_err
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
//   Time-shares the work-RAM port between the CPU and the hiscore engine.
//   A hiscore request pauses the CPU. The block waits for pause confirmation
//   and then for SETTLE ce ticks. After that the RAM port belongs to the
//   hiscore engine. When the request drops, the port returns to the CPU and
//   the pause is released on the next ce tick.
// Ports
//   clk   : system clock (clk_sys domain)
//   reset : asynchronous, active-high
//   ce    : clock enable used for the settle and release timing
//   bus   : hs_ram_arbiter_if.slave (hiscore, pause, CPU and RAM signals)
// Parameters
//   AW      : RAM address width
//   SETTLE  : ce ticks between confirmed pause and grant (1..15)
//   TIMEOUT : clk cycles to wait for pause confirmation (>= 2)
module hs_ram_arbiter #(
  parameter int AW      = 12,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input logic            clk,
  input logic            reset,
  input logic            ce,
  hs_ram_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PAUSE, S_SETTLE, S_GRANT, S_RELEASE
  } state_t;

  state_t        state;
  logic          owner;
  logic          pause_req;
  logic          hs_grant;
  logic          timeout_err;
  logic [TW-1:0] tcnt;
  logic [3:0]    scnt;
  logic [7:0]    hs_rdata;
  logic [AW-1:0] addr_mux;

  // owner is a register, so the RAM mux changes only on a clock edge.
  // An async reset clears it immediately.
  assign addr_mux        = owner ? bus.hs_addr  : bus.cpu_addr;
  assign bus.ram_addr    = addr_mux;
  assign bus.ram_wdata   = owner ? bus.hs_wdata : bus.cpu_wdata;
  assign bus.ram_we      = owner ? bus.hs_we    : bus.cpu_we;
  assign bus.hs_grant    = hs_grant;
  assign bus.pause_req   = pause_req;
  assign bus.timeout_err = timeout_err;
  assign bus.hs_rdata    = hs_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      pause_req   <= 1'b0;
      hs_grant    <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      scnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          owner     <= 1'b0;
          pause_req <= 1'b0;
          if (bus.hs_req) begin
            state     <= S_WAIT_PAUSE;
            pause_req <= 1'b1;
            tcnt      <= '0;
          end
        end
        S_WAIT_PAUSE: begin
          if (!bus.hs_req) begin
            state <= S_RELEASE;
          end else if (bus.cpu_paused) begin
            state <= S_SETTLE;
            scnt  <= 4'(SETTLE);
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // The pause block never confirmed. Give up and flag it.
            timeout_err <= 1'b1;
            pause_req   <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_SETTLE: begin
          if (!bus.hs_req) begin
            state <= S_RELEASE;
          end else if (!bus.cpu_paused) begin
            // The timeout budget continues from where it stopped.
            state <= S_WAIT_PAUSE;
          end else if (ce) begin
            if (scnt == 4'd1) begin
              state    <= S_GRANT;
              owner    <= 1'b1;
              hs_grant <= 1'b1;
            end else begin
              scnt <= scnt - 4'd1;
            end
          end
        end
        S_GRANT: begin
          if (!bus.hs_req) begin
            state    <= S_RELEASE;
            owner    <= 1'b0;
            hs_grant <= 1'b0;
          end
        end
        S_RELEASE: begin
          // The CPU already owns the port. The pause is held until the next
          // ce tick, so it always drops after ownership has returned.
          if (ce) begin
            pause_req <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          owner     <= 1'b0;
          pause_req <= 1'b0;
          hs_grant  <= 1'b0;
        end
      endcase
    end
  end

  // Read data is captured only while hiscore owns the port, so the CPU's
  // traffic never disturbs the last value the engine read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      hs_rdata <= 8'h00;
    else if (owner) hs_rdata <= bus.ram_rdata;
  end
endmodule
